// File: rtl/glitcher_pkg.sv
// Shared types and constants for the glitcher control path: UART receiver
// state encoding, default bit timing and command/response byte values.
package glitcher_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 104;

    localparam logic [7:0] CMD_PING = 8'h01;
    localparam logic [7:0] RSP_ACK  = 8'hAA;
    localparam logic [7:0] RSP_NACK = 8'hFF;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte channel from uart_rx to the command decoder.
interface uart_rx_if;

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_byte,
        output rx_strobe,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_byte,
        input rx_strobe,
        input rx_frame_err,
        input rx_busy
    );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen by the user so an idle-high line does not look active out of reset.
module bit_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, sticky framing
// error, and a fixed-width strobe for every good byte.
module uart_rx
    import glitcher_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    uart_rx_if.master  rx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned STB_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (STROBE_CYCLES == 0 || STROBE_CYCLES >= CLKS_PER_BIT ||
        CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_param_check
        $error("uart_rx: illegal CLKS_PER_BIT / STROBE_CYCLES combination");
    end

    logic rx_s;

    bit_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    uart_rx_state_t   state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       byte_reg;
    logic             err_reg;
    logic             busy_reg;
    logic [STB_W-1:0] stb_cnt_reg;
    logic             strobe_reg;
    logic             stop_good;

    // A good stop sample is the single event that publishes a byte.
    assign stop_good = (state_reg == RX_STOP) && (cnt_reg == LAST) && rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            byte_reg  <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF) begin
                        if (!rx_s) begin
                            state_reg <= RX_DATA;
                            cnt_reg   <= '0;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= RX_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == LAST) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        cnt_reg   <= '0;
                        if (idx_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == LAST) begin
                        if (rx_s) begin
                            byte_reg  <= shift_reg;
                            err_reg   <= 1'b0;
                            state_reg <= RX_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= RX_BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_BREAK: begin
                    // Hold here until the line idles so a stuck-low line yields nothing.
                    if (rx_s) begin
                        state_reg <= RX_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= RX_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Strobe is registered off the counter so it rises one edge after rx_byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_cnt_reg <= '0;
            strobe_reg  <= 1'b0;
        end else begin
            if (stop_good) begin
                stb_cnt_reg <= STB_W'(STROBE_CYCLES);
            end else if (stb_cnt_reg != '0) begin
                stb_cnt_reg <= stb_cnt_reg - 1'b1;
            end
            strobe_reg <= (stb_cnt_reg != '0);
        end
    end

    assign rx.rx_byte      = byte_reg;
    assign rx.rx_strobe    = strobe_reg;
    assign rx.rx_frame_err = err_reg;
    assign rx.rx_busy      = busy_reg;

endmodule
